// File: rtl/reg_scoreboard.sv
// reg_scoreboard: dual-issue register scoreboard tracking pending writes for 32 registers
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   i0_valid, i0_rs1/rs2/rd    older issue slot and its register addresses (0 = unused)
//   i1_valid, i1_rs1/rs2/rd    younger issue slot and its register addresses (0 = unused)
//   wb0_en/rd, wb1_en/rd       writeback retire strobes and destination registers
//   flush                      synchronous clear of all reservations
//   i0_issue, i1_issue         combinational issue grants
//   busy_vec, busy_cnt         registered pending-write bits and their population count
module reg_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i0_valid,
    input  logic [4:0]  i0_rs1,
    input  logic [4:0]  i0_rs2,
    input  logic [4:0]  i0_rd,
    input  logic        i1_valid,
    input  logic [4:0]  i1_rs1,
    input  logic [4:0]  i1_rs2,
    input  logic [4:0]  i1_rd,
    input  logic        wb0_en,
    input  logic [4:0]  wb0_rd,
    input  logic        wb1_en,
    input  logic [4:0]  wb1_rd,
    input  logic        flush,
    output logic        i0_issue,
    output logic        i1_issue,
    output logic [31:0] busy_vec,
    output logic [5:0]  busy_cnt
);
    logic        conflict;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [31:0] nxt;
    logic [5:0]  nxt_cnt;

    // bit 0 of busy_vec is held at 0, so address 0 never raises a hazard
    assign conflict = (i0_rd != 5'd0) && (i0_rd == i1_rs1 || i0_rd == i1_rs2 || i0_rd == i1_rd);
    assign i0_issue = i0_valid && !flush && !(busy_vec[i0_rs1] || busy_vec[i0_rs2] || busy_vec[i0_rd]);
    assign i1_issue = i0_issue && i1_valid && !conflict
                      && !(busy_vec[i1_rs1] || busy_vec[i1_rs2] || busy_vec[i1_rd]);

    assign set_vec = (i0_issue ? 32'd1 << i0_rd : 32'd0) | (i1_issue ? 32'd1 << i1_rd : 32'd0);
    assign clr_vec = (wb0_en ? 32'd1 << wb0_rd : 32'd0) | (wb1_en ? 32'd1 << wb1_rd : 32'd0);
    // set is applied after clear so a same-cycle reservation wins over a retire
    assign nxt = flush ? 32'd0 : ((busy_vec & ~clr_vec) | set_vec) & ~32'd1;

    always_comb begin
        nxt_cnt = '0;
        for (int i = 0; i < 32; i++) nxt_cnt = nxt_cnt + 6'(nxt[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec <= '0;
            busy_cnt <= '0;
        end else begin
            busy_vec <= nxt;
            busy_cnt <= nxt_cnt;
        end
    end
endmodule
